prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, instruction-memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 1000000, clk cycles allowed between received bytes during a load.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_req  input  1  single-cycle request to start a program load.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe marking a received UART byte.
REQ-007 SHALL have port rx_data  input  8  received byte; valid only while rx_valid=1.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
REQ-009 SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port cpu_rst_n  output  1  drives datapath rst_n; 0 holds the datapath in reset.
REQ-012 SHALL have port busy  output  1  high while a load is in progress.
REQ-013 SHALL have port done  output  1  sticky; last load completed successfully.
REQ-014 SHALL have port err  output  1  sticky; last load aborted (timeout or length overflow).

Function
REQ-015 SHALL implement states IDLE, LEN0, LEN1, DATA, FINISH, ERROR; all outputs registered.
REQ-016 SHALL, in IDLE, on load_req=1 go to LEN0, clear done/err, zero word index and byte index, set busy=1 and cpu_rst_n=0 next cycle.
REQ-017 SHALL capture rx_data as len[7:0] in LEN0 and len[15:8] in LEN1, advancing one state per rx_valid.
REQ-018 SHALL, leaving LEN1: len==0 -> FINISH; len > 2^ADDR_W -> ERROR; otherwise -> DATA.
REQ-019 SHALL, in DATA, assemble bytes little-endian (1st byte -> bits 7:0, 4th -> bits 31:24).
REQ-020 SHALL assert imem_we=1 for exactly one cycle, the cycle after the 4th byte's rx_valid, with imem_addr=word index and imem_wdata=assembled word; word index then increments by 1.
REQ-021 SHALL go to FINISH with the write of word len-1; no further writes.
REQ-022 SHALL, in FINISH, set done=1 and busy=0 for one cycle then go to IDLE; cpu_rst_n SHALL return to 1 on entering IDLE.
REQ-023 SHALL keep an inter-byte counter, cleared on every rx_valid and on entry to LEN0; reaching TIMEOUT in LEN0/LEN1/DATA -> ERROR.
REQ-024 SHALL, in ERROR, hold cpu_rst_n=0, busy=0, err=1, no writes; leave ERROR only on load_req (-> LEN0, as REQ-016).
REQ-025 SHALL ignore rx_valid in IDLE, FINISH and ERROR, and ignore load_req in LEN0/LEN1/DATA/FINISH.
REQ-026 SHALL discard any partial word (fewer than 4 bytes) on abort; it is never written.
REQ-027 SHALL keep imem_we=0 in every state except the REQ-020 pulse cycle.

Reset
REQ-028 SHALL, while reset=1, force state IDLE, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, cpu_rst_n=0, all counters 0.
REQ-029 SHALL drive cpu_rst_n=1 on the first clock edge with reset=0 in IDLE.
REQ-030 SHALL, on reset mid-load, abandon the load with no further imem_we pulse.

Verification
REQ-031 Load: len=0x0002, bytes 13 00 00 00 93 00 10 00 -> imem_we pulses: addr 0 data 0x00000013, addr 1 data 0x00100093; done=1, cpu_rst_n 0 during load, 1 after.
REQ-032 Zero length: load_req, bytes 00 00 -> no imem_we, FINISH then IDLE, done=1, err=0.
REQ-033 Overflow: ADDR_W=4, len=0x0011 -> ERROR, err=1, cpu_rst_n=0, no writes; new load_req restarts cleanly.
REQ-034 Timeout: TIMEOUT=100, len=1, 2 data bytes then silence -> ERROR at 100 cycles after last byte, no write, err=1.
REQ-035 Reset mid-DATA after 2 of 4 bytes -> IDLE, all outputs at reset values, no imem_we, cpu_rst_n=1 one cycle after reset drops.
REQ-036 Noise: rx_valid bytes in IDLE and load_req during DATA -> ignored; in-progress load writes the correct words.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bus between the UART side and the loader.
// The loader takes the slave modport; the host/testbench takes the master modport.
interface prog_loader_if #(
  parameter int ADDR_W = 14
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// UART program loader: takes a 16-bit little-endian word count followed by
// little-endian 32-bit words and writes them into instruction memory.
module prog_loader #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_req,
  prog_loader_if.slave bus,
  output logic         cpu_rst_n,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN0   = 3'd1;
  localparam logic [2:0] ST_LEN1   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  logic [2:0]        state_r,      state_s;
  logic [15:0]       len_r,        len_s;
  logic [23:0]       word_r,       word_s;
  logic [1:0]        byte_idx_r,   byte_idx_s;
  logic [ADDR_W-1:0] word_idx_r,   word_idx_s;
  logic [TMR_W-1:0]  tmr_r,        tmr_s;
  logic              imem_we_r,    imem_we_s;
  logic [ADDR_W-1:0] imem_addr_r,  imem_addr_s;
  logic [31:0]       imem_wdata_r, imem_wdata_s;
  logic              busy_r,       busy_s;
  logic              done_r,       done_s;
  logic              err_r,        err_s;
  logic              cpu_rst_n_r,  cpu_rst_n_s;

  logic [15:0]       len_full_s;
  logic              tmr_hit_s;
  logic              last_word_s;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_s      = state_r;
    len_s        = len_r;
    word_s       = word_r;
    byte_idx_s   = byte_idx_r;
    word_idx_s   = word_idx_r;
    tmr_s        = tmr_r;
    imem_we_s    = 1'b0;
    imem_addr_s  = imem_addr_r;
    imem_wdata_s = imem_wdata_r;
    busy_s       = busy_r;
    done_s       = done_r;
    err_s        = err_r;
    cpu_rst_n_s  = cpu_rst_n_r;

    len_full_s  = {bus.rx_data, len_r[7:0]};
    tmr_hit_s   = (tmr_r == TMR_W'(TIMEOUT - 1));
    last_word_s = (17'(word_idx_r) == ({1'b0, len_r} - 17'd1));

    case (state_r)
      ST_IDLE, ST_ERROR: begin
        // rx_valid is ignored here; only a new load request leaves these states.
        if (load_req) begin
          state_s     = ST_LEN0;
          len_s       = 16'd0;
          word_s      = 24'd0;
          byte_idx_s  = 2'd0;
          word_idx_s  = {ADDR_W{1'b0}};
          tmr_s       = {TMR_W{1'b0}};
          busy_s      = 1'b1;
          done_s      = 1'b0;
          err_s       = 1'b0;
          cpu_rst_n_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
          cpu_rst_n_s = 1'b1;
        end else begin
          cpu_rst_n_s = 1'b0;
        end
      end

      ST_LEN0: begin
        if (bus.rx_valid) begin
          len_s[7:0] = bus.rx_data;
          tmr_s      = {TMR_W{1'b0}};
          state_s    = ST_LEN1;
        end else if (tmr_hit_s) begin
          state_s     = ST_ERROR;
          err_s       = 1'b1;
          busy_s      = 1'b0;
          cpu_rst_n_s = 1'b0;
        end else begin
          tmr_s = tmr_r + TMR_W'(1);
        end
      end

      ST_LEN1: begin
        if (bus.rx_valid) begin
          len_s = len_full_s;
          tmr_s = {TMR_W{1'b0}};
          if (len_full_s == 16'd0) begin
            state_s = ST_FINISH;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else if ({1'b0, len_full_s} > MAX_LEN) begin
            state_s     = ST_ERROR;
            err_s       = 1'b1;
            busy_s      = 1'b0;
            cpu_rst_n_s = 1'b0;
          end else begin
            state_s = ST_DATA;
          end
        end else if (tmr_hit_s) begin
          state_s     = ST_ERROR;
          err_s       = 1'b1;
          busy_s      = 1'b0;
          cpu_rst_n_s = 1'b0;
        end else begin
          tmr_s = tmr_r + TMR_W'(1);
        end
      end

      ST_DATA: begin
        if (bus.rx_valid) begin
          tmr_s = {TMR_W{1'b0}};
          case (byte_idx_r)
            2'd0: begin
              word_s[7:0] = bus.rx_data;
              byte_idx_s  = 2'd1;
            end
            2'd1: begin
              word_s[15:8] = bus.rx_data;
              byte_idx_s   = 2'd2;
            end
            2'd2: begin
              word_s[23:16] = bus.rx_data;
              byte_idx_s    = 2'd3;
            end
            2'd3: begin
              // Fourth byte goes straight into the write data; the pulse lands next cycle.
              imem_we_s    = 1'b1;
              imem_addr_s  = word_idx_r;
              imem_wdata_s = {bus.rx_data, word_r};
              word_idx_s   = word_idx_r + ADDR_W'(1);
              byte_idx_s   = 2'd0;
              if (last_word_s) begin
                state_s = ST_FINISH;
                done_s  = 1'b1;
                busy_s  = 1'b0;
              end else begin
                state_s = ST_DATA;
              end
            end
            default: begin
              byte_idx_s = 2'd0;
            end
          endcase
        end else if (tmr_hit_s) begin
          // Any partially assembled word is simply dropped.
          state_s     = ST_ERROR;
          err_s       = 1'b1;
          busy_s      = 1'b0;
          cpu_rst_n_s = 1'b0;
        end else begin
          tmr_s = tmr_r + TMR_W'(1);
        end
      end

      ST_FINISH: begin
        state_s     = ST_IDLE;
        cpu_rst_n_s = 1'b1;
      end

      default: begin
        state_s     = ST_IDLE;
        busy_s      = 1'b0;
        cpu_rst_n_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      len_r        <= 16'd0;
      word_r       <= 24'd0;
      byte_idx_r   <= 2'd0;
      word_idx_r   <= {ADDR_W{1'b0}};
      tmr_r        <= {TMR_W{1'b0}};
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {ADDR_W{1'b0}};
      imem_wdata_r <= 32'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      cpu_rst_n_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      len_r        <= len_s;
      word_r       <= word_s;
      byte_idx_r   <= byte_idx_s;
      word_idx_r   <= word_idx_s;
      tmr_r        <= tmr_s;
      imem_we_r    <= imem_we_s;
      imem_addr_r  <= imem_addr_s;
      imem_wdata_r <= imem_wdata_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      err_r        <= err_s;
      cpu_rst_n_r  <= cpu_rst_n_s;
    end
  end

  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign cpu_rst_n      = cpu_rst_n_r;

endmodule
